// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-side strobes for mem_arbiter.
// The arbiter uses the slave view; whoever drives requests and memory responses uses master.
interface mem_arbiter_if;
  logic       req0, req1;
  logic       wr0, wr1;
  logic [7:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rd_data;
  logic       err;
  logic [1:0] gnt;
  logic       mem_read, mem_write;
  logic [7:0] addr_bus, mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    output ack0, ack1, rd_data, err, gnt, mem_read, mem_write, addr_bus, mem_wdata
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
    input  ack0, ack1, rd_data, err, gnt, mem_read, mem_write, addr_bus, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with a bounded mem_ready wait and timeout abort.
// All outputs are registered; a single access is in flight at any time.
module mem_arbiter #(
  parameter int WAIT_MAX = 15
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  // state  | meaning
  // IDLE   | no owner; requests sampled at every edge
  // ACCESS | strobe held toward memory until mem_ready or timeout
  // RESP   | one-cycle ack (with err qualifier) to the owner
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t     state, state_nxt;
  logic       last_q, last_nxt;
  logic [7:0] wait_q, wait_nxt, wait_inc;
  logic [1:0] gnt_q, gnt_nxt;
  logic       ack0_q, ack0_nxt, ack1_q, ack1_nxt;
  logic       err_q, err_nxt;
  logic       rd_q, rd_nxt, wr_q, wr_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic [7:0] rdata_q, rdata_nxt;
  logic       pick1, sel_wr;
  logic [7:0] sel_addr, sel_wdata;

  // Port 1 wins when alone, or on a tie when port 0 was served last.
  assign pick1     = bus.req1 & (~bus.req0 | ~last_q);
  assign sel_wr    = pick1 ? bus.wr1 : bus.wr0;
  assign sel_addr  = pick1 ? bus.addr1 : bus.addr0;
  assign sel_wdata = pick1 ? bus.wdata1 : bus.wdata0;
  assign wait_inc  = wait_q + 8'd1;

  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    wait_nxt  = wait_q;
    gnt_nxt   = gnt_q;
    ack0_nxt  = ack0_q;
    ack1_nxt  = ack1_q;
    err_nxt   = err_q;
    rd_nxt    = rd_q;
    wr_nxt    = wr_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;

    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          gnt_nxt   = pick1 ? 2'b10 : 2'b01;
          last_nxt  = pick1;
          rd_nxt    = ~sel_wr;
          wr_nxt    = sel_wr;
          addr_nxt  = sel_addr;
          wdata_nxt = sel_wdata;
          wait_nxt  = 8'd0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          if (rd_q) rdata_nxt = bus.mem_rdata;
          err_nxt   = 1'b0;
          ack0_nxt  = gnt_q[0];
          ack1_nxt  = gnt_q[1];
          state_nxt = RESP;
        end else if (wait_inc == WAIT_LIM) begin
          // The WAIT_MAX-th edge without mem_ready aborts the access.
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          err_nxt   = 1'b1;
          ack0_nxt  = gnt_q[0];
          ack1_nxt  = gnt_q[1];
          wait_nxt  = wait_inc;
          state_nxt = RESP;
        end else begin
          wait_nxt  = wait_inc;
        end
      end
      RESP: begin
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        err_nxt   = 1'b0;
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      last_q  <= 1'b1;
      wait_q  <= 8'd0;
      gnt_q   <= 2'b00;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state   <= state_nxt;
      last_q  <= last_nxt;
      wait_q  <= wait_nxt;
      gnt_q   <= gnt_nxt;
      ack0_q  <= ack0_nxt;
      ack1_q  <= ack1_nxt;
      err_q   <= err_nxt;
      rd_q    <= rd_nxt;
      wr_q    <= wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err       = err_q;
  assign bus.mem_read  = rd_q;
  assign bus.mem_write = wr_q;
  assign bus.addr_bus  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rd_data   = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int WAIT_MAX = 15;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         port;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         delay;
    int         exp_strb;
    bit         exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  // random-traffic model state
  bit         pend [2];
  bit         w_m  [2];
  logic [7:0] a_m  [2];
  logic [7:0] wd_m [2];
  int         last_m;
  logic [7:0] rd_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.mem_rdata = 0; bus.mem_ready = 0;
  endtask

  // Runs one isolated access and reports what the memory side and requester saw.
  task automatic run_txn(input vec_t v, output int strb, output int acks, output int wrong,
                         output int bad, output logic e, output logic [7:0] rd,
                         output logic [7:0] ab, output logic [7:0] wdo);
    logic good_kind;
    strb = 0; acks = 0; wrong = 0; bad = 0; e = 0; rd = 0; ab = 0; wdo = 0;
    clear_inputs();
    bus.mem_rdata = v.rdata;
    if (v.port == 0) begin
      bus.req0 = 1; bus.wr0 = v.wr; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end else begin
      bus.req1 = 1; bus.wr1 = v.wr; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end
    for (int c = 0; c < 40; c++) begin
      tick();
      good_kind = v.wr ? (bus.mem_write && !bus.mem_read) : (bus.mem_read && !bus.mem_write);
      if (good_kind) begin
        strb++;
        ab  = bus.addr_bus;
        wdo = bus.mem_wdata;
      end else if (bus.mem_read || bus.mem_write) begin
        bad++;
      end
      if ((v.port == 0 && bus.ack0) || (v.port == 1 && bus.ack1)) begin
        acks++;
        e  = bus.err;
        rd = bus.rd_data;
        bus.req0 = 0;
        bus.req1 = 0;
      end
      if ((v.port == 0 && bus.ack1) || (v.port == 1 && bus.ack0)) wrong++;
      bus.mem_ready = good_kind && (strb == v.delay + 1);
    end
  endtask

  task automatic drive_ports();
    bus.req0 = pend[0]; bus.wr0 = w_m[0]; bus.addr0 = a_m[0]; bus.wdata0 = wd_m[0];
    bus.req1 = pend[1]; bus.wr1 = w_m[1]; bus.addr1 = a_m[1]; bus.wdata1 = wd_m[1];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strb, acks, wrong, bad, own, d, n_edges;
    bit tmo;
    logic e;
    logic [7:0] rd, ab, wdo, rdat;

    //          port wr addr   wdata  rdata  delay strb err rd
    vecs[0] = '{0, 0, 8'h3C, 8'h00, 8'hA5, 0,  1,  0, 8'hA5};
    vecs[1] = '{1, 1, 8'h80, 8'h5A, 8'hFF, 3,  4,  0, 8'hA5};
    vecs[2] = '{0, 0, 8'h01, 8'h00, 8'h33, 99, 15, 1, 8'hA5};
    vecs[3] = '{1, 0, 8'h11, 8'h00, 8'h77, 0,  1,  0, 8'h77};
    vecs[4] = '{0, 1, 8'h22, 8'hC3, 8'h00, 14, 15, 0, 8'h77};
    vecs[5] = '{1, 0, 8'h44, 8'h00, 8'h99, 15, 15, 1, 8'h77};
    vecs[6] = '{0, 0, 8'hFE, 8'h00, 8'h5C, 13, 14, 0, 8'h5C};

    rst = 1'b0;
    clear_inputs();
    repeat (2) tick();
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_acks", {bus.ack1, bus.ack0}, 2'b00);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_strobes", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("rst_addr_bus", bus.addr_bus, 8'h00);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    chk("rst_rd_data", bus.rd_data, 8'h00);

    // Tie straight out of reset: port 0 first, then strict alternation.
    bus.req0 = 1; bus.req1 = 1; bus.mem_ready = 1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_gnt", bus.gnt, (i % 2) ? 2'b10 : 2'b01);
      tick();
      chk("tie_ack", {bus.ack1, bus.ack0}, (i % 2) ? 2'b10 : 2'b01);
      chk("tie_err", bus.err, 1'b0);
      tick();
      chk("tie_resp_clear", {bus.gnt, bus.ack1, bus.ack0}, 4'b0000);
      if (i == 3) clear_inputs();
    end

    foreach (vecs[i]) begin
      run_txn(vecs[i], strb, acks, wrong, bad, e, rd, ab, wdo);
      chk($sformatf("vec%0d_strobe_cycles", i), strb, vecs[i].exp_strb);
      chk($sformatf("vec%0d_ack_count", i), acks, 1);
      chk($sformatf("vec%0d_wrong_ack", i), wrong, 0);
      chk($sformatf("vec%0d_bad_strobe", i), bad, 0);
      chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      chk($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_addr_bus", i), ab, vecs[i].addr);
      if (vecs[i].wr) chk($sformatf("vec%0d_mem_wdata", i), wdo, vecs[i].wdata);
    end

    // Owner changes address and drops req after grant; access continues unchanged.
    clear_inputs();
    bus.req0 = 1; bus.addr0 = 8'h10; bus.mem_rdata = 8'h6E;
    tick();
    chk("chg_gnt", bus.gnt, 2'b01);
    chk("chg_addr0", bus.addr_bus, 8'h10);
    bus.addr0 = 8'h20; bus.req0 = 0;
    tick();
    chk("chg_addr1", bus.addr_bus, 8'h10);
    chk("chg_read_held", bus.mem_read, 1'b1);
    bus.mem_ready = 1;
    tick();
    chk("chg_ack", {bus.ack1, bus.ack0}, 2'b01);
    chk("chg_addr2", bus.addr_bus, 8'h10);
    chk("chg_rd", bus.rd_data, 8'h6E);
    bus.mem_ready = 0;
    tick();

    // Reset in the middle of an access.
    bus.req0 = 1; bus.addr0 = 8'h66;
    tick();
    chk("mid_read_on", bus.mem_read, 1'b1);
    tick();
    #1 rst = 1'b0;
    #1;
    chk("mid_strobes_async", {bus.mem_read, bus.mem_write}, 2'b00);
    chk("mid_gnt_async", bus.gnt, 2'b00);
    chk("mid_addr_async", bus.addr_bus, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_no_ack", {bus.ack1, bus.ack0}, 2'b00);
    end
    rst = 1'b1;
    tick();
    chk("mid_regrant", bus.gnt, 2'b01);
    bus.mem_rdata = 8'h42; bus.mem_ready = 1;
    tick();
    chk("mid_ack", {bus.ack1, bus.ack0}, 2'b01);
    chk("mid_rd", bus.rd_data, 8'h42);
    clear_inputs();
    tick();

    // Randomized traffic against a transaction-level model.
    last_m = 0;
    rd_m = 8'h42;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 250; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1;
          w_m[p]  = 1'($urandom_range(0, 1));
          a_m[p]  = 8'($urandom);
          wd_m[p] = 8'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        own = int'($urandom_range(0, 1));
        pend[own] = 1; w_m[own] = 0; a_m[own] = 8'($urandom); wd_m[own] = 8'($urandom);
      end
      drive_ports();
      own = (pend[0] && pend[1]) ? 1 - last_m : (pend[1] ? 1 : 0);
      last_m = own;
      d = int'($urandom_range(0, WAIT_MAX + 2));
      rdat = 8'($urandom);
      bus.mem_ready = 0;
      bus.mem_rdata = rdat;
      tick();
      chk("rnd_gnt", bus.gnt, own ? 2'b10 : 2'b01);
      chk("rnd_addr", bus.addr_bus, a_m[own]);
      chk("rnd_strobe", {bus.mem_read, bus.mem_write}, w_m[own] ? 2'b01 : 2'b10);
      if (w_m[own]) chk("rnd_wdata", bus.mem_wdata, wd_m[own]);
      if (own == 0) begin
        bus.addr0 = ~a_m[0]; bus.wdata0 = ~wd_m[0]; bus.wr0 = ~w_m[0]; bus.req0 = 1'($urandom_range(0, 1));
      end else begin
        bus.addr1 = ~a_m[1]; bus.wdata1 = ~wd_m[1]; bus.wr1 = ~w_m[1]; bus.req1 = 1'($urandom_range(0, 1));
      end
      tmo = (d >= WAIT_MAX);
      n_edges = tmo ? WAIT_MAX : d + 1;
      for (int k = 1; k <= n_edges; k++) begin
        bus.mem_ready = (k == d + 1);
        tick();
        if (k < n_edges) begin
          chk("rnd_wait_strobe", {bus.mem_read, bus.mem_write}, w_m[own] ? 2'b01 : 2'b10);
          chk("rnd_wait_addr", bus.addr_bus, a_m[own]);
          chk("rnd_wait_noack", {bus.ack1, bus.ack0}, 2'b00);
        end
      end
      if (!w_m[own] && !tmo) rd_m = rdat;
      chk("rnd_ack", {bus.ack1, bus.ack0}, own ? 2'b10 : 2'b01);
      chk("rnd_err", bus.err, tmo);
      chk("rnd_strobes_off", {bus.mem_read, bus.mem_write}, 2'b00);
      chk("rnd_rd_data", bus.rd_data, rd_m);
      pend[own] = 0;
      bus.mem_ready = 0;
      tick();
      chk("rnd_resp_clear", {bus.gnt, bus.ack1, bus.ack0, bus.err}, 5'b00000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 15, giving the maximum mem_ready wait in cycles before the access is aborted.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have ports req0 / req1, input, 1 each, access requests from port 0 (control unit) and port 1 (loader/DMA).
REQ-005 The block SHALL have ports wr0 / wr1, input, 1 each, access direction (1 = write, 0 = read).
REQ-006 The block SHALL have ports addr0 / addr1, input, 8 each, access addresses.
REQ-007 The block SHALL have ports wdata0 / wdata1, input, 8 each, write data.
REQ-008 The block SHALL have port ack0 / ack1, output, 1 each, one-cycle completion pulse to the owning port.
REQ-009 The block SHALL have port rd_data, output, 8, read data, valid while ack0 or ack1 is high.
REQ-010 The block SHALL have port err, output, 1, qualifies ack: 1 = access timed out.
REQ-011 The block SHALL have port gnt, output, 2, one-hot current owner; 00 when idle.
REQ-012 The block SHALL have ports mem_read / mem_write, output, 1 each, memory strobes.
REQ-013 The block SHALL have ports addr_bus, output, 8, and mem_wdata, output, 8, the memory address and write data.
REQ-014 The block SHALL have ports mem_rdata, input, 8, and mem_ready, input, 1, memory read data and completion.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS, RESP. All outputs SHALL be registered.
REQ-016 In IDLE with any req high at a clock edge, the FSM SHALL select an owner and move to ACCESS. The owner SHALL be set in gnt. The owner's wr, addr and wdata SHALL be latched into the memory outputs.
REQ-017 Arbitration SHALL be round-robin. With both reqs high, the port other than the last-served port wins. With one req high, that port wins regardless of history.
REQ-018 The last-served register SHALL update only on grant.
REQ-019 During ACCESS, exactly one of mem_read / mem_write SHALL be high, per the latched wr. addr_bus and mem_wdata SHALL be held stable.
REQ-020 In ACCESS, mem_ready=1 at an edge SHALL cause the following:
- strobes deassert;
- rd_data captures mem_rdata (reads only; writes leave rd_data unchanged);
- err is set to 0;
- the owner's ack is set;
- the FSM moves to RESP.
REQ-021 An 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with mem_ready=0. When it equals WAIT_MAX with mem_ready still 0, the FSM SHALL:
- deassert strobes;
- set err=1;
- set the owner's ack;
- move to RESP.
REQ-022 RESP SHALL last exactly one cycle. On leaving RESP:
- ack, err and gnt clear;
- the FSM returns to IDLE;
- new requests are evaluated at the next edge.
REQ-023 Zero-wait latency: req sampled at edge k; strobes are high during cycle k..k+1; mem_ready seen at edge k+1; ack is high for cycle k+1..k+2; next grant is possible at edge k+3.
REQ-024 Requesters SHALL hold req, wr, addr and wdata until ack. Changes to the owner's inputs after grant SHALL be ignored. The non-owner's req SHALL remain pending, with no loss.
REQ-025 A req still high in IDLE after its ack SHALL be treated as a new request.
REQ-026 At most one ack SHALL be high in any cycle. mem_read and mem_write SHALL never be high together.
REQ-027 A deasserted owner req during ACCESS SHALL NOT abort the access.

Reset
REQ-028 While rst=0, the following SHALL be forced asynchronously:
- state = IDLE;
- gnt = 00;
- ack0 = ack1 = 0;
- err = 0;
- mem_read = mem_write = 0;
- addr_bus = mem_wdata = rd_data = 00;
- wait counter = 0;
- last-served = port 1, so port 0 wins the first tie.
REQ-029 Reset asserted mid-ACCESS SHALL drop the strobes immediately and SHALL produce no ack.
REQ-030 After rst rises, the first grant SHALL be possible at the first clock edge.

Verification
REQ-031 Single read: req0=1, wr0=0, addr0=0x3C, mem_rdata=0xA5, mem_ready=1 -> mem_read high one cycle with addr_bus=0x3C; ack0 then pulses with rd_data=0xA5 and err=0.
REQ-032 Tie after reset: req0=req1=1 held -> grants alternate 01, 10, 01, 10; acks alternate ack0, ack1; port 0 goes first.
REQ-033 Write with waits: req1=1, wr1=1, addr1=0x80, wdata1=0x5A, mem_ready low 3 cycles -> mem_write high 4 cycles with mem_wdata=0x5A; ack1 pulses once; rd_data unchanged.
REQ-034 Timeout: req0 read, mem_ready held 0 -> strobes drop after WAIT_MAX=15 waiting edges; ack0=1 with err=1; the next access has err=0.
REQ-035 Reset mid-access: rst=0 during ACCESS -> mem_read/mem_write/gnt go to 0 without a clock edge; no ack; after rst=1 a pending req0 is granted at the next edge.
REQ-036 Input change after grant: addr0 changes 0x10->0x20 during ACCESS -> addr_bus stays 0x10 until ack0.
